if_id_queue: RTL



---
 rtl/riscv_pkg.sv | 18 +
 rtl/if_id_queue.sv | 90 +++++++++
 2 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions.
//   NOP_INSTR   : canonical NOP (addi x0,x0,0), shown on decode when idle
//   PC_W        : program-counter width
//   INSTR_W     : instruction word width
//   ifq_entry_t : {pc, instr} pair carried from fetch to decode
package riscv_pkg;

  localparam int unsigned PC_W    = 64;
  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode.
// Buffers {pc, instr} pairs so a decode stall never drops fetched
// instructions; a branch redirect (flush) discards everything buffered.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : fetch-side handshake (push on both high)
//   in_pc, in_instr   : fetched entry, sampled only on a push edge
//   flush             : synchronous discard of all entries, highest priority
//   out_valid/out_ready : decode-side handshake (pop on both high)
//   out_pc, out_instr : head entry (0 / NOP when empty)
//   out_misaligned    : head entry's pc[1:0] != 0
//   count             : occupied entries, 0..DEPTH
module if_id_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned PC_W    = 64,
  parameter int unsigned INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_misaligned,
  output logic [$clog2(DEPTH):0]   count
);

  import riscv_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Both ready/valid flags depend only on the registered count, so there is
  // no combinational path from out_ready to in_ready.
  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    out_pc         = '0;
    out_instr      = INSTR_W'(NOP_INSTR);
    out_misaligned = 1'b0;
    if (out_valid) begin
      out_pc         = pc_mem[rd_ptr];
      out_instr      = instr_mem[rd_ptr];
      out_misaligned = (pc_mem[rd_ptr][1:0] != 2'b00);
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is never cleared; only pointers and count define what is live.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule
